// File: rtl/sfifo_pkg.sv
// sfifo_pkg: width helpers, flag reset values and parameter range check for sfifo
package sfifo_pkg;

    localparam logic RST_WFULL  = 1'b0;
    localparam logic RST_REMPTY = 1'b1;
    localparam logic RST_AFULL  = 1'b0;
    localparam logic RST_AEMPTY = 1'b1;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_ok(input int depth, input int afull_th, input int aempty_th);
        return depth >= 2 && afull_th >= 1 && afull_th <= depth && aempty_th >= 0 && aempty_th <= depth - 1;
    endfunction

endpackage

// File: rtl/sfifo_if.sv
// sfifo_if: push/pop, status and error signals of sfifo
// master: drives winc, wdata, rinc; slave (the fifo): drives rdata, wfull, rempty,
// almost_full, almost_empty, count, overflow, underflow
interface sfifo_if import sfifo_pkg::*; #(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 16
);
    localparam int CNTW = cnt_w(DEPTH);
    logic                winc;
    logic [DATASIZE-1:0] wdata;
    logic                rinc;
    logic [DATASIZE-1:0] rdata;
    logic                wfull;
    logic                rempty;
    logic                almost_full;
    logic                almost_empty;
    logic [CNTW-1:0]     count;
    logic                overflow;
    logic                underflow;
    modport master (
        output winc, wdata, rinc,
        input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  winc, wdata, rinc,
        output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sfifo_mem.sv
// sfifo_mem: DEPTH x DATASIZE storage, synchronous write, registered read with enable
// ports: clk, rst (sync, clears rdata only), we/waddr/wdata write port, re/raddr/rdata read port
module sfifo_mem #(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 16,
    parameter int ADDRW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDRW-1:0]    waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                re,
    input  logic [ADDRW-1:0]    raddr,
    output logic [DATASIZE-1:0] rdata
);
    logic [DATASIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/sfifo.sv
// sfifo: single-clock FIFO with exact count, threshold flags and optional sticky error flags
// ports: clk, rst (sync active-high), bus (sfifo_if.slave: winc/wdata/rinc in,
// rdata/wfull/rempty/almost_full/almost_empty/count/overflow/underflow out)
// define SFIFO_ERR_EN to build the sticky overflow/underflow registers; otherwise both read 0
module sfifo import sfifo_pkg::*; #(
    parameter int DATASIZE  = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input logic   clk,
    input logic   rst,
    sfifo_if.slave bus
);
    localparam int ADDRW = addr_w(DEPTH);
    localparam int CNTW  = cnt_w(DEPTH);

    if (!params_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("sfifo: DEPTH, AFULL_TH or AEMPTY_TH out of range");
    end

    logic             push, pop;
    logic [ADDRW-1:0] wptr, rptr;
    logic [CNTW-1:0]  count_q, count_next;
    logic             wfull_q, rempty_q, afull_q, aempty_q;

    // a pop frees a slot in the same cycle, so a full fifo still accepts a push alongside it
    assign pop        = bus.rinc & ~rempty_q;
    assign push       = bus.winc & (~wfull_q | pop);
    assign count_next = count_q + CNTW'(push) - CNTW'(pop);

    always_ff @(posedge clk)
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            wfull_q  <= RST_WFULL;
            rempty_q <= RST_REMPTY;
            afull_q  <= RST_AFULL;
            aempty_q <= RST_AEMPTY;
        end else begin
            // explicit wrap keeps non-power-of-two depths correct
            if (push) wptr <= (wptr == ADDRW'(DEPTH - 1)) ? '0 : wptr + ADDRW'(1);
            if (pop) rptr <= (rptr == ADDRW'(DEPTH - 1)) ? '0 : rptr + ADDRW'(1);
            count_q  <= count_next;
            wfull_q  <= count_next == CNTW'(DEPTH);
            rempty_q <= count_next == '0;
            afull_q  <= count_next >= CNTW'(AFULL_TH);
            aempty_q <= count_next <= CNTW'(AEMPTY_TH);
        end

    sfifo_mem #(.DATASIZE(DATASIZE), .DEPTH(DEPTH), .ADDRW(ADDRW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wptr),
        .wdata (bus.wdata),
        .re    (pop),
        .raddr (rptr),
        .rdata (bus.rdata)
    );

    assign bus.count        = count_q;
    assign bus.wfull        = wfull_q;
    assign bus.rempty       = rempty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;

`ifdef SFIFO_ERR_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk)
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.winc & ~push);
            unf_q <= unf_q | (bus.rinc & rempty_q);
        end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule
